// File: rtl/system_if.sv
// Serial link bus: groups the channel control input and the recovered data output.
//   channel_interrupt : 1 breaks the channel (received line forced to 0)
//   receiver_data_o   : recovered serial payload bit stream
// Modports: master = environment side, slave = link (system) side.
interface system_if;
  logic channel_interrupt;
  logic receiver_data_o;

  modport master (
    output channel_interrupt,
    input  receiver_data_o
  );

  modport slave (
    input  channel_interrupt,
    output receiver_data_o
  );
endinterface

// File: rtl/system.sv
// Framed serial link: transmitter, breakable channel and locking receiver on one clock.
// The transmitter sends back-to-back 16-bit NRZ frames {SYNC_WORD, frame counter}, MSB first,
// one bit per BIT_DIV clocks. The receiver recovers bit timing from line edges, hunts for
// SYNC_WORD, then emits each payload bit on receiver_data_o and flywheels over up to
// LOSS_LIMIT-1 consecutive missed sync words.
// Ports:
//   receiver_LO     : clock for all logic (rising edge)
//   receiver_rst    : receiver async reset, active low
//   transmitter_rst : transmitter async reset, active low
//   bus             : system_if.slave (channel_interrupt in, receiver_data_o out)
// BIT_DIV must be even and within 4..64.
module system #(
  parameter int unsigned BIT_DIV    = 8,
  parameter logic [7:0]  SYNC_WORD  = 8'hA7,
  parameter int unsigned LOSS_LIMIT = 2
) (
  input  logic    receiver_LO,
  input  logic    receiver_rst,
  input  logic    transmitter_rst,
  system_if.slave bus
);

  localparam int unsigned PhaseW = $clog2(BIT_DIV);
  localparam logic [PhaseW-1:0] PhaseMax = PhaseW'(BIT_DIV - 1);
  localparam logic [PhaseW-1:0] SampleAt = PhaseW'(BIT_DIV / 2 - 1);

  // ---------------- transmitter ----------------
  logic [PhaseW-1:0] tx_timer_q;
  logic [3:0]        tx_idx_q;
  logic [7:0]        frame_cnt_q;
  logic [15:0]       tx_frame;
  logic              tx_bit;
  logic              line;

  always_ff @(posedge receiver_LO or negedge transmitter_rst) begin
    if (!transmitter_rst) begin
      tx_timer_q  <= '0;
      tx_idx_q    <= '0;
      frame_cnt_q <= '0;
    end else if (tx_timer_q == PhaseMax) begin
      tx_timer_q <= '0;
      tx_idx_q   <= tx_idx_q + 4'd1;
      if (tx_idx_q == 4'd15) frame_cnt_q <= frame_cnt_q + 8'd1;
    end else begin
      tx_timer_q <= tx_timer_q + 1'b1;
    end
  end

  assign tx_frame = {SYNC_WORD, frame_cnt_q};
  // ~idx == 15-idx: MSB first. Gated so the bit reads 0 while held in reset.
  assign tx_bit   = transmitter_rst & tx_frame[~tx_idx_q];

  // ---------------- channel (combinational) ----------------
  assign line = tx_bit & ~bus.channel_interrupt;

  // ---------------- receiver ----------------
  typedef enum logic [1:0] {StHunt, StPayload, StCheck} rx_state_e;

  rx_state_e         state_q, state_d;
  logic              sync1_q, line_q, prev_q;
  logic [PhaseW-1:0] phase_q, phase_d;
  logic [7:0]        shift_q, shift_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        miss_q, miss_d, miss_inc;
  logic              data_q, data_d;
  logic              sample;

  assign sample   = (phase_q == SampleAt);
  assign miss_inc = miss_q + 8'd1;

  always_comb begin
    // Any line transition realigns the bit phase; otherwise free-run so long runs still sample.
    phase_d = '0;
    if (line_q == prev_q && phase_q != PhaseMax) phase_d = phase_q + 1'b1;
  end

  // Shift value including the bit sampled this cycle, so sync is seen with no extra delay.
  assign shift_d = sample ? {shift_q[6:0], line_q} : shift_q;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    miss_d    = miss_q;
    data_d    = data_q;
    if (sample) begin
      unique case (state_q)
        StHunt: begin
          data_d = 1'b0;
          if (shift_d == SYNC_WORD) begin
            state_d   = StPayload;
            bit_cnt_d = '0;
            miss_d    = '0;
          end
        end
        StPayload: begin
          data_d    = line_q;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = StCheck;
        end
        StCheck: begin
          data_d    = 1'b0;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (shift_d == SYNC_WORD) begin
              miss_d  = '0;
              state_d = StPayload;
            end else begin
              miss_d  = miss_inc;
              state_d = (miss_inc >= 8'(LOSS_LIMIT)) ? StHunt : StPayload;
            end
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  always_ff @(posedge receiver_LO or negedge receiver_rst) begin
    if (!receiver_rst) begin
      sync1_q   <= 1'b0;
      line_q    <= 1'b0;
      prev_q    <= 1'b0;
      phase_q   <= '0;
      shift_q   <= '0;
      state_q   <= StHunt;
      bit_cnt_q <= '0;
      miss_q    <= '0;
      data_q    <= 1'b0;
    end else begin
      sync1_q   <= line;
      line_q    <= sync1_q;
      prev_q    <= line_q;
      phase_q   <= phase_d;
      shift_q   <= shift_d;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      miss_q    <= miss_d;
      data_q    <= data_d;
    end
  end

  assign bus.receiver_data_o = data_q;

endmodule

// File: tb/tb_system.sv
// Directed bench for the serial link: lock-up, counter wrap, channel breaks,
// receiver reset and transmitter reset. Timing is tracked in clock edges from the
// last transmitter reset release; each payload bit is read mid-way through its hold.
module tb_system;
  logic clk = 1'b0;
  logic rx_rst;
  logic tx_rst;
  int   cyc = 0;
  int   tx_base = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  system_if bus ();

  system dut (
    .receiver_LO    (clk),
    .receiver_rst   (rx_rst),
    .transmitter_rst(tx_rst),
    .bus            (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Return 1 ns after rising edge number n.
  task automatic wait_edge(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Edge at which transmit slot g (bit index since tx reset release) starts.
  function automatic int slot(input int g);
    return tx_base + 8 * g;
  endfunction

  task automatic pl_check(input int f, input logic [7:0] exp);
    logic [7:0] v = 8'h00;
    for (int j = 0; j < 8; j++) begin
      wait_edge(slot(16 * f + 8 + j) + 10);
      v = {v[6:0], bus.receiver_data_o};
    end
    check($sformatf("payload frame %0d", f), v, exp);
  endtask

  task automatic zero_check(input string tag, input int g);
    wait_edge(slot(g) + 10);
    check(tag, 8'(bus.receiver_data_o), 8'h00);
  endtask

  initial begin
    rx_rst = 1'b0;
    tx_rst = 1'b0;
    bus.channel_interrupt = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("data in reset", 8'(bus.receiver_data_o), 8'h00);
    @(negedge clk);
    rx_rst  = 1'b1;
    tx_rst  = 1'b1;
    tx_base = cyc;

    // Before the first sync completes the output stays 0.
    for (int g = 0; g < 8; g++) zero_check("hunt before lock", g);

    // Counter frames 0..257 including the FF -> 00 wrap, with CHECK-window zeros early on.
    for (int f = 0; f < 258; f++) begin
      if (f >= 1 && f < 4) zero_check($sformatf("check window frame %0d", f), 16 * f + 3);
      pl_check(f, 8'(f));
    end

    // Channel broken for frames 260..262: two misses drop lock, relock on 263.
    wait_edge(slot(16 * 260));
    bus.channel_interrupt = 1'b1;
    pl_check(260, 8'h00);
    pl_check(261, 8'h00);
    wait_edge(slot(16 * 263));
    bus.channel_interrupt = 1'b0;
    pl_check(263, 8'h07);
    pl_check(264, 8'h08);

    // Break covering only the sync word of frame 266: flywheel holds lock.
    wait_edge(slot(16 * 266));
    bus.channel_interrupt = 1'b1;
    zero_check("check during break", 16 * 266 + 3);
    wait_edge(slot(16 * 266 + 8));
    bus.channel_interrupt = 1'b0;
    pl_check(266, 8'h0A);
    pl_check(267, 8'h0B);

    // Receiver reset during payload bit 3 (a 1) of frame 272 = 8'h10.
    wait_edge(slot(16 * 272 + 11) + 10);
    check("rx payload before reset", 8'(bus.receiver_data_o), 8'h01);
    rx_rst = 1'b0;
    #1;
    check("rx reset clears data", 8'(bus.receiver_data_o), 8'h00);
    repeat (2) @(negedge clk);
    rx_rst = 1'b1;
    zero_check("hunt after rx reset", 16 * 273 + 2);
    pl_check(273, 8'h11);

    // Transmitter reset for one bit slot inside frame 275's payload; counter restarts at 0.
    // Receiver misses twice on its old frame grid, then locks on the new frame 2 sync.
    wait_edge(slot(16 * 275 + 10));
    tx_rst = 1'b0;
    wait_edge(slot(16 * 275 + 11));
    @(negedge clk);
    tx_rst  = 1'b1;
    tx_base = cyc;
    pl_check(2, 8'h02);
    pl_check(3, 8'h03);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
